// File: rtl/lsu_pkg.sv
// Shared types for the load/store adapter: access sizes, one-hot FSM states
// and the alignment rule.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_RSV = 2'd3
  } size_e;

  localparam int unsigned ST_IDLE_BIT  = 0;
  localparam int unsigned ST_LOAD_BIT  = 1;
  localparam int unsigned ST_RMW_BIT   = 2;
  localparam int unsigned ST_WRITE_BIT = 3;
  localparam int unsigned ST_RESP_BIT  = 4;

  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_LOAD   = 5'b00010,
    S_RMW_RD = 5'b00100,
    S_WRITE  = 5'b01000,
    S_RESP   = 5'b10000
  } lsu_state_e;

  function automatic logic is_misaligned(input size_e size, input logic [1:0] a);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return a[0];
      SZ_W:    return |a;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: extracts/extends a load lane from a memory word and merges
// store data into a word for read-modify-write.
module lsu_align
  import lsu_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b       = word[{lane, 3'b000} +: 8];
    h       = lane[1] ? word[31:16] : word[15:0];
    ld_data = '0;
    st_word = word;
    case (size)
      SZ_B: begin
        ld_data = {{24{b[7] & ~is_unsigned}}, b};
        st_word[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_H: begin
        ld_data = {{16{h[15] & ~is_unsigned}}, h};
        if (lane[1]) st_word[31:16] = wdata[15:0];
        else         st_word[15:0]  = wdata[15:0];
      end
      SZ_W: begin
        ld_data = word;
        st_word = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_adapter.sv
// Load/store adapter from the execute stage to a word-only memory port.
// Optional LSU_BOUNDS_CHECK_EN flags req_addr >= MEM_BYTES as an error.
module lsu_mem_adapter
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] d_addr,
  output logic [31:0] d_wdata,
  output logic        d_we,
  input  logic [31:0] d_rdata
);

`ifdef LSU_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  lsu_state_e  state, state_nx;
  logic [31:0] addr_q, wdata_q, merge_q, rdata_q;
  size_e       size_q;
  logic        uns_q, err_q;
  logic        accept, req_err;
  size_e       req_size_e;
  logic [31:0] ld_data, st_word;

  assign req_size_e = size_e'(req_size);
  assign accept     = req_valid & req_ready;
  assign req_err    = is_misaligned(req_size_e, req_addr[1:0])
                    | (BOUNDS_EN & (req_addr >= MEM_BYTES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (req_err)                 state_nx = S_RESP;
          else if (!req_we)            state_nx = S_LOAD;
          else if (req_size_e == SZ_W) state_nx = S_WRITE;
          else                         state_nx = S_RMW_RD;
        end
      end
      S_LOAD:   state_nx = S_RESP;
      S_RMW_RD: state_nx = S_WRITE;
      S_WRITE:  state_nx = S_RESP;
      S_RESP:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Strobes come straight off registered one-hot bits, so d_we cannot glitch.
  always_comb begin
    req_ready = state[ST_IDLE_BIT] & ~rst;
    rsp_valid = state[ST_RESP_BIT];
    d_we      = state[ST_WRITE_BIT];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        size_q  <= req_size_e;
        uns_q   <= req_unsigned;
        err_q   <= req_err;
        rdata_q <= '0;
        merge_q <= req_wdata;  // word stores write this directly
      end
      if (state[ST_LOAD_BIT]) rdata_q <= ld_data;
      if (state[ST_RMW_BIT])  merge_q <= st_word;
    end
  end

  lsu_align u_align (
    .size        (size_q),
    .lane        (addr_q[1:0]),
    .is_unsigned (uns_q),
    .word        (d_rdata),
    .wdata       (wdata_q),
    .ld_data     (ld_data),
    .st_word     (st_word)
  );

  assign d_addr    = {addr_q[31:2], 2'b00};
  assign d_wdata   = merge_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
